// File: rtl/decimal_bcd_encoder_reg_if.sv
// Decimal select lines in, registered BCD digit with valid/err qualifiers out.
// The master drives D0..D9. The slave (the encoder) drives the registered results.
interface decimal_bcd_encoder_reg_if;
    logic D0, D1, D2, D3, D4, D5, D6, D7, D8, D9;
    logic A, B, C, D;
    logic valid;
    logic err;

    modport master (
        output D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
        input  A, B, C, D, valid, err
    );

    modport slave (
        input  D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
        output A, B, C, D, valid, err
    );
endinterface

// File: rtl/decimal_bcd_encoder_reg.sv
// Registered 10-line decimal-to-BCD priority encoder. The highest set line wins.
// Define DEC_BCD_ONEHOT_CHECK_EN to register a multi-hot error flag; otherwise err is tied low.
module decimal_bcd_encoder_reg (
    input  logic                        clk,
    input  logic                        rst_n,
    decimal_bcd_encoder_reg_if.slave    bus
);

    logic [9:0] sel;
    logic [3:0] code_d, code_q;
    logic       valid_d, valid_q;

    assign sel = {bus.D9, bus.D8, bus.D7, bus.D6, bus.D5,
                  bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};

    // Ascending scan, so the highest asserted index overwrites the lower ones.
    always_comb begin
        code_d  = 4'd0;
        valid_d = |sel;
        for (int i = 0; i < 10; i++) begin
            if (sel[i]) begin
                code_d = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

`ifdef DEC_BCD_ONEHOT_CHECK_EN
    logic err_d, err_q;

    // Clearing the lowest set bit leaves something only when two or more lines are high.
    always_comb begin
        err_d = |(sel & (sel - 10'd1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.A     = code_q[3];
    assign bus.B     = code_q[2];
    assign bus.C     = code_q[1];
    assign bus.D     = code_q[0];
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_decimal_bcd_encoder_reg.sv
// Directed self-checking bench for decimal_bcd_encoder_reg.
// err expectations follow DEC_BCD_ONEHOT_CHECK_EN.
module tb_decimal_bcd_encoder_reg;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    decimal_bcd_encoder_reg_if bus ();

    decimal_bcd_encoder_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic driveLines(input logic [9:0] v);
        bus.D0 = v[0]; bus.D1 = v[1]; bus.D2 = v[2]; bus.D3 = v[3]; bus.D4 = v[4];
        bus.D5 = v[5]; bus.D6 = v[6]; bus.D7 = v[7]; bus.D8 = v[8]; bus.D9 = v[9];
    endtask

    // Inputs change on the falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic [9:0] v);
        @(negedge clk);
        driveLines(v);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_code,
                               input logic exp_valid, input logic multi);
        logic [3:0] obs_code;
        logic       exp_err;
`ifdef DEC_BCD_ONEHOT_CHECK_EN
        exp_err = multi;
`else
        exp_err = 1'b0;
        if (multi) exp_err = 1'b0;
`endif
        obs_code = {bus.A, bus.B, bus.C, bus.D};
        tests_run++;
        assert (obs_code === exp_code) else begin
            tests_failed++;
            $error("[TB] FAIL %s code: observed %b expected %b", tag, obs_code, exp_code);
        end
        tests_run++;
        assert (bus.valid === exp_valid) else begin
            tests_failed++;
            $error("[TB] FAIL %s valid: observed %b expected %b", tag, bus.valid, exp_valid);
        end
        tests_run++;
        assert (bus.err === exp_err) else begin
            tests_failed++;
            $error("[TB] FAIL %s err: observed %b expected %b", tag, bus.err, exp_err);
        end
    endtask

    task automatic sampleAfterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        driveLines(10'b10_1010_0101);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_async_no_edge", 4'b0000, 1'b0, 1'b0);
        sampleAfterEdge();
        checkOutput("reset_held_over_edge", 4'b0000, 1'b0, 1'b0);

        // Lines 0,2,5,7,9 are high, so 9 wins.
        @(negedge clk);
        rst_n = 1'b1;
        sampleAfterEdge();
        checkOutput("release_multi_hot", 4'b1001, 1'b1, 1'b1);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(10'b1 << k);
            sampleAfterEdge();
            checkOutput($sformatf("walk_D%0d", k), 4'(k), 1'b1, 1'b0);
        end

        applyStimulus(10'b00_0000_0000);
        sampleAfterEdge();
        checkOutput("none_high", 4'b0000, 1'b0, 1'b0);
        applyStimulus(10'b00_0000_0001);
        sampleAfterEdge();
        checkOutput("d0_only", 4'b0000, 1'b1, 1'b0);

        applyStimulus(10'b00_1000_1000);
        sampleAfterEdge();
        checkOutput("d3_d7", 4'b0111, 1'b1, 1'b1);
        applyStimulus(10'b11_1111_1111);
        sampleAfterEdge();
        checkOutput("all_high", 4'b1001, 1'b1, 1'b1);
        applyStimulus(10'b11_0000_0000);
        sampleAfterEdge();
        checkOutput("d8_d9", 4'b1001, 1'b1, 1'b1);
        applyStimulus(10'b00_0000_0110);
        sampleAfterEdge();
        checkOutput("d1_d2", 4'b0010, 1'b1, 1'b1);
        applyStimulus(10'b00_0000_0011);
        sampleAfterEdge();
        checkOutput("d0_d1", 4'b0001, 1'b1, 1'b1);
        applyStimulus(10'b01_0000_0000);
        sampleAfterEdge();
        checkOutput("d8_only", 4'b1000, 1'b1, 1'b0);

        // A mid-cycle reset must drop the outputs with no clock edge involved.
        applyStimulus(10'b10_0000_0000);
        sampleAfterEdge();
        checkOutput("d9_before_reset", 4'b1001, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_async", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sampleAfterEdge();
        checkOutput("d9_after_release", 4'b1001, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
